timer_event_gen: RTL

- Upstream stage of the up/down timer counter; produces the single-cycle `counter_event` strobe that advances it.
- Selects one of NUM_INPUTS external/internal trigger lines, synchronises it and qualifies it by mode (level/edge).
- Divides qualified events by a programmable prescaler.
- Shares update/reset/active control with the counter it feeds.

---
 rtl/timer_event_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/timer_event_gen.sv
// Trigger selection, synchronisation, mode qualification and prescaling that
// produce the counter_event strobe. Optional TIMER_EVT_GLITCH_FILTER_EN adds a 3-sample stability filter.
module timer_event_gen #(
   parameter int NUM_INPUTS = 4,
   parameter int PRESC_BITS = 8,
   localparam int SEL_BITS = $clog2(NUM_INPUTS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_INPUTS-1:0] signal_i,
   input  logic [SEL_BITS-1:0]   cfg_sel_i,
   input  logic [2:0]            cfg_mode_i,
   input  logic [PRESC_BITS-1:0] cfg_presc_i,
   input  logic                  ctrl_update_i,
   input  logic                  ctrl_rst_i,
   input  logic                  ctrl_active_i,
   output logic                  event_o,
   output logic [PRESC_BITS-1:0] presc_cnt_o
);

   logic [NUM_INPUTS-1:0] sync1_q, sync1_d;
   logic [NUM_INPUTS-1:0] sync2_q, sync2_d;
   logic [SEL_BITS-1:0]   sel_q, sel_d;
   logic [2:0]            mode_q, mode_d;
   logic [PRESC_BITS-1:0] presc_q, presc_d;
   logic [PRESC_BITS-1:0] cnt_q, cnt_d;
   logic                  hist_q, hist_d;
   logic                  evt_q, evt_d;

   logic s_sync;
   logic s_new;
   logic s;
   logic raw;

   assign s_sync = sync2_q[sel_q];
   assign s_new  = sync2_q[cfg_sel_i];

`ifdef TIMER_EVT_GLITCH_FILTER_EN
   logic [1:0] sh_q, sh_d;
   logic       flt_q, flt_d;
   logic       flt_val;

   // Filtered level moves only once the current and two previous samples agree.
   always_comb begin
      flt_val = flt_q;
      if (s_sync && sh_q[0] && sh_q[1]) begin
         flt_val = 1'b1;
      end else if (!s_sync && !sh_q[0] && !sh_q[1]) begin
         flt_val = 1'b0;
      end
   end

   assign s = flt_val;
`else
   assign s = s_sync;
`endif

   always_comb begin
      raw = 1'b0;
      case (mode_q)
         3'd0:    raw = 1'b1;
         3'd1:    raw = s;
         3'd2:    raw = ~s;
         3'd3:    raw = s & ~hist_q;
         3'd4:    raw = ~s & hist_q;
         3'd5:    raw = s ^ hist_q;
         default: raw = 1'b0;
      endcase
   end

   always_comb begin
      sync1_d = signal_i;
      sync2_d = sync1_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      presc_d = presc_q;
      hist_d  = s;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
`ifdef TIMER_EVT_GLITCH_FILTER_EN
      sh_d    = {sh_q[0], s_sync};
      flt_d   = flt_val;
`endif
      if (ctrl_update_i) begin
         sel_d   = cfg_sel_i;
         mode_d  = cfg_mode_i;
         presc_d = cfg_presc_i;
         // Seed history from the new line so a select change is not an edge.
         hist_d  = s_new;
         cnt_d   = '0;
`ifdef TIMER_EVT_GLITCH_FILTER_EN
         sh_d    = {2{s_new}};
         flt_d   = s_new;
`endif
      end else if (ctrl_rst_i) begin
         cnt_d = '0;
      end else if (raw && ctrl_active_i) begin
         if (cnt_q == presc_q) begin
            cnt_d = '0;
            evt_d = 1'b1;
         end else begin
            cnt_d = cnt_q + PRESC_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sel_q   <= '0;
         mode_q  <= '0;
         presc_q <= '0;
         hist_q  <= 1'b0;
         cnt_q   <= '0;
         evt_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         presc_q <= presc_d;
         hist_q  <= hist_d;
         cnt_q   <= cnt_d;
         evt_q   <= evt_d;
      end
   end

`ifdef TIMER_EVT_GLITCH_FILTER_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_q  <= '0;
         flt_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         flt_q <= flt_d;
      end
   end
`endif

   assign event_o     = evt_q;
   assign presc_cnt_o = cnt_q;

endmodule
